// File: rtl/xc_cmd_pkg.sv
// Shared definitions for the correlator control-port command stream.
// Request codes, wire opcodes and sequence lengths are used by the encoder
// and by the correlator decoder bench.
package xc_cmd_pkg;

    // High-level request codes presented on cmd_op.
    typedef enum logic [2:0] {
        OP_CLEAR        = 3'd0,
        OP_SET_LEDS     = 3'd1,
        OP_SET_BAUD     = 3'd2,
        OP_SET_CROSS    = 3'd3,
        OP_SET_AUTO     = 3'd4,
        OP_SET_FREQ_DIV = 3'd5,
        OP_SET_VOLTAGE  = 3'd6,
        OP_CAPTURE      = 3'd7
    } cmd_op_e;

    // Encoder sequencing phases.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PREFIX = 2'd1,
        ST_BODY   = 2'd2
    } enc_state_e;

    // Wire opcodes carried in the low nibble of each command byte.
    localparam logic [3:0] WIRE_CLEAR          = 4'h0;
    localparam logic [3:0] WIRE_SET_INDEX      = 4'h1;
    localparam logic [3:0] WIRE_SET_LEDS       = 4'h2;
    localparam logic [3:0] WIRE_SET_BAUD_RATE  = 4'h3;
    localparam logic [3:0] WIRE_DELAY_BASE     = 4'h4;
    localparam logic [3:0] WIRE_SET_FREQ_DIV   = 4'h8;
    localparam logic [3:0] WIRE_SET_VOLTAGE    = 4'h9;
    localparam logic [3:0] WIRE_ENABLE_CAPTURE = 4'hD;

    // Delay bytes carry {auto, slice[2:0], 2'b01, k[1:0]}; this is the
    // fixed 2'b01 field that makes the low nibble read as 0x4|k.
    localparam logic [1:0] DELAY_MARKER = WIRE_DELAY_BASE[3:2];

    // Sequence lengths in bytes.
    localparam int PREFIX_BYTES      = 4;
    localparam int DELAY_BODY_BYTES  = 5;
    localparam int NIBBLE_BODY_BYTES = 1;

    // Requests that address one correlator line and therefore need a valid
    // index and possibly a SET_INDEX prefix.
    function automatic logic is_per_line(input cmd_op_e op);
        return (op == OP_CLEAR) || (op == OP_SET_LEDS) || (op == OP_SET_CROSS) ||
               (op == OP_SET_AUTO) || (op == OP_SET_VOLTAGE);
    endfunction

    // Requests that carry a saturating delay value split into 3-bit slices.
    function automatic logic is_delay(input cmd_op_e op);
        return (op == OP_SET_CROSS) || (op == OP_SET_AUTO);
    endfunction

endpackage

// File: rtl/xc_cmd_encoder.sv
// Host-side command encoder for the correlator UART control port.
// Takes one request at a time, expands it into an optional 4-byte index
// prefix followed by a 1- or 5-byte body, and streams the bytes out over a
// valid/ready handshake. The last index sent is cached so consecutive
// requests to the same line skip the prefix.
module xc_cmd_encoder
    import xc_cmd_pkg::*;
#(
    parameter int NUM_INPUTS = 8,
    parameter int DELAY_SIZE = 150
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_index,
    input  logic [11:0] cmd_value,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        cmd_error,
    output logic        busy
);

    localparam logic [7:0]  LP_NUM_INPUTS  = 8'(NUM_INPUTS);
    localparam logic [11:0] LP_MAX_DELAY   = 12'(DELAY_SIZE - 1);
    localparam logic [2:0]  LP_LAST_PREFIX = 3'(PREFIX_BYTES - 1);
    localparam logic [2:0]  LP_LAST_DELAY  = 3'(DELAY_BODY_BYTES - 1);
    localparam logic [2:0]  LP_LAST_NIBBLE = 3'(NIBBLE_BODY_BYTES - 1);

    // Sequencer state and latched request.
    enc_state_e  r_state;
    logic [2:0]  r_cnt;
    cmd_op_e     r_op;
    logic [7:0]  r_idx;
    logic [11:0] r_val;

    // Index cache: last line index fully delivered to the decoder.
    logic        r_cache_valid;
    logic [7:0]  r_cache_idx;

    // Registered outputs.
    logic [7:0]  r_byte_out;
    logic        r_byte_valid;
    logic        r_cmd_error;

    // Next-state / control.
    enc_state_e  w_next_state;
    logic [2:0]  w_next_cnt;
    logic        w_xfer;
    logic        w_load_fields;
    logic        w_cache_load;
    logic        w_error;
    logic        w_need_prefix;
    logic        w_body_last;
    cmd_op_e     w_op;
    logic [7:0]  w_idx;
    logic [11:0] w_val;
    logic [7:0]  w_next_byte;

    // Builds the command byte for a given phase and byte position. In the
    // delay body the fifth byte repeats the k=3 byte: the decoder applies the
    // value it latched on the previous byte, so the repeat commits it.
    function automatic logic [7:0] encode_byte(
        input enc_state_e  st,
        input logic [2:0]  cnt,
        input cmd_op_e     op,
        input logic [7:0]  idx,
        input logic [11:0] val
    );
        logic [1:0] k;
        logic [1:0] idx_pair;
        logic [1:0] dk;
        logic [2:0] val_slice;
        logic [7:0] result;

        result    = 8'h00;
        k         = cnt[1:0];
        dk        = (cnt >= 3'd3) ? 2'd3 : cnt[1:0];

        case (k)
            2'd0:    idx_pair = idx[1:0];
            2'd1:    idx_pair = idx[3:2];
            2'd2:    idx_pair = idx[5:4];
            default: idx_pair = idx[7:6];
        endcase

        case (dk)
            2'd0:    val_slice = val[2:0];
            2'd1:    val_slice = val[5:3];
            2'd2:    val_slice = val[8:6];
            default: val_slice = val[11:9];
        endcase

        if (st == ST_PREFIX) begin
            result = {k, idx_pair, WIRE_SET_INDEX};
        end else if (st == ST_BODY) begin
            case (op)
                OP_CLEAR:        result = {4'h0, WIRE_CLEAR};
                OP_SET_LEDS:     result = {val[3:0], WIRE_SET_LEDS};
                OP_SET_BAUD:     result = {val[3:0], WIRE_SET_BAUD_RATE};
                OP_SET_FREQ_DIV: result = {val[3:0], WIRE_SET_FREQ_DIV};
                OP_SET_VOLTAGE:  result = {val[3:0], WIRE_SET_VOLTAGE};
                OP_CAPTURE:      result = {3'b000, val[0], WIRE_ENABLE_CAPTURE};
                OP_SET_CROSS:    result = {1'b0, val_slice, DELAY_MARKER, dk};
                OP_SET_AUTO:     result = {1'b1, val_slice, DELAY_MARKER, dk};
                default:         result = 8'h00;
            endcase
        end
        return result;
    endfunction

    assign w_xfer      = r_byte_valid & byte_ready;
    assign w_body_last = is_delay(r_op) ? (r_cnt == LP_LAST_DELAY)
                                        : (r_cnt == LP_LAST_NIBBLE);

    // Next-state, request acceptance and byte-position advance.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state  = r_state;
        w_next_cnt    = r_cnt;
        w_load_fields = 1'b0;
        w_cache_load  = 1'b0;
        w_error       = 1'b0;
        w_need_prefix = 1'b0;
        w_op          = r_op;
        w_idx         = r_idx;
        w_val         = r_val;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_op  = cmd_op_e'(cmd_op);
                    w_idx = cmd_index;
                    w_val = cmd_value;
                    if (is_per_line(w_op) && (cmd_index >= LP_NUM_INPUTS)) begin
                        // Out-of-range line: flag and stay idle, nothing sent.
                        w_error = 1'b1;
                    end else begin
                        w_load_fields = 1'b1;
                        if (is_delay(w_op) && (cmd_value > LP_MAX_DELAY)) begin
                            // Saturate but still send the request.
                            w_error = 1'b1;
                            w_val   = LP_MAX_DELAY;
                        end
                        w_need_prefix = is_per_line(w_op) &&
                                        (!r_cache_valid || (cmd_index != r_cache_idx));
                        w_next_state  = w_need_prefix ? ST_PREFIX : ST_BODY;
                        w_next_cnt    = 3'd0;
                    end
                end
            end

            ST_PREFIX: begin
                if (w_xfer) begin
                    if (r_cnt == LP_LAST_PREFIX) begin
                        w_next_state = ST_BODY;
                        w_next_cnt   = 3'd0;
                        w_cache_load = 1'b1;
                    end else begin
                        w_next_cnt = r_cnt + 3'd1;
                    end
                end
            end

            ST_BODY: begin
                if (w_xfer) begin
                    if (w_body_last) begin
                        w_next_state = ST_IDLE;
                        w_next_cnt   = 3'd0;
                    end else begin
                        w_next_cnt = r_cnt + 3'd1;
                    end
                end
            end

            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = 3'd0;
            end
        endcase
    end

    // Byte that will be on the bus next cycle; unchanged while stalled
    // because state, count and latched fields all hold.
    assign w_next_byte = encode_byte(w_next_state, w_next_cnt, w_op, w_idx, w_val);

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Byte counter and latched request fields.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 3'd0;
            r_op  <= OP_CLEAR;
            r_idx <= 8'h00;
            r_val <= 12'h000;
        end else begin
            r_cnt <= w_next_cnt;
            if (w_load_fields) begin
                r_op  <= w_op;
                r_idx <= w_idx;
                r_val <= w_val;
            end
        end
    end

    // Index cache, refreshed once the whole prefix has reached the UART.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cache_valid <= 1'b0;
            r_cache_idx   <= 8'h00;
        end else if (w_cache_load) begin
            r_cache_valid <= 1'b1;
            r_cache_idx   <= r_idx;
        end
    end

    // Registered byte stream and error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_byte_out   <= 8'h00;
            r_byte_valid <= 1'b0;
            r_cmd_error  <= 1'b0;
        end else begin
            r_byte_out   <= w_next_byte;
            r_byte_valid <= (w_next_state != ST_IDLE);
            r_cmd_error  <= w_error;
        end
    end

    assign byte_out   = r_byte_out;
    assign byte_valid = r_byte_valid;
    assign cmd_error  = r_cmd_error;
    assign cmd_ready  = (r_state == ST_IDLE);
    assign busy       = ~cmd_ready;

endmodule

// File: tb/tb_xc_cmd_encoder.sv
// Self-checking bench for xc_cmd_encoder: directed scenarios followed by
// randomized requests, all compared against a byte-list reference model.
module tb_xc_cmd_encoder;
    import xc_cmd_pkg::*;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_index;
    logic [11:0] cmd_value;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        cmd_error;
    logic        busy;

    int tests = 0;
    int fails = 0;

    // Reference model state.
    logic [7:0] exp_q[$];
    logic       exp_err;
    int         model_cache = -1;

    xc_cmd_encoder #(.NUM_INPUTS(8), .DELAY_SIZE(150)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_index  (cmd_index),
        .cmd_value  (cmd_value),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .cmd_error  (cmd_error),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected byte list for one request, built directly from the command
    // format: prefix bytes carry 2-bit index pairs, delay bytes carry 3-bit
    // value slices of the saturated value.
    task automatic model(input cmd_op_e op, input int idx, input int val);
        bit per_line;
        int v;
        int kk;
        exp_q.delete();
        exp_err  = 1'b0;
        per_line = (op == OP_CLEAR) || (op == OP_SET_LEDS) || (op == OP_SET_CROSS) ||
                   (op == OP_SET_AUTO) || (op == OP_SET_VOLTAGE);
        if (per_line && idx >= 8) begin
            exp_err = 1'b1;
            return;
        end
        if (per_line && idx != model_cache) begin
            for (int k = 0; k < 4; k++)
                exp_q.push_back(8'(k * 64 + ((idx / (4 ** k)) % 4) * 16 + 1));
            model_cache = idx;
        end
        case (op)
            OP_CLEAR:        exp_q.push_back(8'h00);
            OP_SET_LEDS:     exp_q.push_back(8'((val % 16) * 16 + 2));
            OP_SET_BAUD:     exp_q.push_back(8'((val % 16) * 16 + 3));
            OP_SET_FREQ_DIV: exp_q.push_back(8'((val % 16) * 16 + 8));
            OP_SET_VOLTAGE:  exp_q.push_back(8'((val % 16) * 16 + 9));
            OP_CAPTURE:      exp_q.push_back(8'((val % 2) * 16 + 13));
            default: begin
                v       = (val > 149) ? 149 : val;
                exp_err = (val > 149);
                for (int k = 0; k < 5; k++) begin
                    kk = (k > 3) ? 3 : k;
                    exp_q.push_back(8'(((op == OP_SET_AUTO) ? 128 : 0) +
                                       ((v / (8 ** kk)) % 8) * 16 + 4 + kk));
                end
            end
        endcase
    endtask

    // Issue one request and follow it to completion. stall_pct sets the
    // chance of byte_ready low per cycle; hold_at forces a 10-cycle stall
    // when that many bytes remain; poke drives junk requests while busy.
    task automatic run_req(input cmd_op_e op, input logic [7:0] idx, input logic [11:0] val,
                           input int stall_pct, input int hold_at, input bit poke);
        logic [7:0] held;
        bit         have_held;
        int         budget;
        int         stall_cnt;
        bit         stall_done;
        model(op, int'(idx), int'(val));
        @(negedge clk);
        check("ready_before_req", 32'(cmd_ready), 32'(1'b1));
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_index = idx;
        cmd_value = val;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("cmd_error_n1", 32'(cmd_error), 32'(exp_err));
        if (exp_q.size() == 0) begin
            check("reject_no_valid", 32'(byte_valid), 32'(1'b0));
            check("reject_ready", 32'(cmd_ready), 32'(1'b1));
            @(negedge clk);
            check("reject_err_pulse_end", 32'(cmd_error), 32'(1'b0));
            check("reject_ready_hold", 32'(cmd_ready), 32'(1'b1));
            check("reject_still_no_valid", 32'(byte_valid), 32'(1'b0));
        end else begin
            check("first_byte_valid_n1", 32'(byte_valid), 32'(1'b1));
            check("busy_during", 32'(busy), 32'(1'b1));
            have_held  = 1'b0;
            budget     = 0;
            stall_cnt  = 0;
            stall_done = 1'b0;
            while (exp_q.size() > 0 && budget < 400) begin
                if (budget == 1)
                    check("err_pulse_one_cycle", 32'(cmd_error), 32'(1'b0));
                check("valid_while_pending", 32'(byte_valid), 32'(1'b1));
                if (have_held)
                    check("byte_held_in_stall", 32'(byte_out), 32'(held));
                if (!stall_done && exp_q.size() == hold_at) begin
                    byte_ready = 1'b0;
                    stall_cnt++;
                    if (stall_cnt == 10) stall_done = 1'b1;
                end else begin
                    byte_ready = ($urandom_range(99) >= stall_pct);
                end
                if (byte_valid && byte_ready) begin
                    check("byte_value", 32'(byte_out), 32'(exp_q.pop_front()));
                    have_held = 1'b0;
                end else if (byte_valid) begin
                    held      = byte_out;
                    have_held = 1'b1;
                end
                if (poke) begin
                    cmd_valid = 1'b1;
                    cmd_op    = 3'($urandom_range(7));
                    cmd_index = 8'($urandom_range(255));
                    cmd_value = 12'($urandom_range(4095));
                end
                @(negedge clk);
                budget++;
            end
            cmd_valid  = 1'b0;
            byte_ready = 1'b0;
            check("bytes_left_at_end", 32'(exp_q.size()), 32'd0);
            check("ready_after_last", 32'(cmd_ready), 32'(1'b1));
            check("valid_after_last", 32'(byte_valid), 32'(1'b0));
            if (poke)
                check("busy_request_ignored_err", 32'(cmd_error), 32'(1'b0));
        end
    endtask

    initial begin
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 3'd0;
        cmd_index  = 8'h00;
        cmd_value  = 12'h000;
        byte_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'(1'b1));
        check("rst_byte_valid", 32'(byte_valid), 32'(1'b0));
        check("rst_byte_out", 32'(byte_out), 32'h00);
        check("rst_cmd_error", 32'(cmd_error), 32'(1'b0));
        check("rst_busy", 32'(busy), 32'(1'b0));
        reset = 1'b0;
        model_cache = -1;

        // Directed sequence from the command-format examples.
        run_req(OP_SET_LEDS,    8'd3, 12'h00A, 0, -1, 1'b0);
        run_req(OP_SET_VOLTAGE, 8'd3, 12'd5,   0, -1, 1'b0);
        run_req(OP_SET_AUTO,    8'd3, 12'd90,  0, -1, 1'b0);
        run_req(OP_SET_CROSS,   8'd3, 12'd200, 0, -1, 1'b0);
        run_req(OP_CAPTURE,     8'd0, 12'd1,   0, -1, 1'b0);
        run_req(OP_CLEAR,       8'd8, 12'd0,   0, -1, 1'b0);
        run_req(OP_SET_BAUD,    8'd9, 12'h7F7, 0, -1, 1'b0);
        run_req(OP_SET_FREQ_DIV,8'd0, 12'h00F, 0, -1, 1'b0);
        run_req(OP_CLEAR,       8'd7, 12'h0,   0, -1, 1'b0);
        run_req(OP_SET_CROSS,   8'd7, 12'd149, 0, -1, 1'b0);

        // Long stall in the middle of a delay body, with junk requests
        // presented while busy.
        run_req(OP_SET_AUTO,    8'd2, 12'd123, 0, 3, 1'b1);

        // Reset in the middle of the index prefix.
        model(OP_SET_LEDS, 5, 6);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_SET_LEDS;
        cmd_index = 8'd5;
        cmd_value = 12'd6;
        @(negedge clk);
        cmd_valid  = 1'b0;
        check("rst_mid_first_byte", 32'(byte_out), 32'(exp_q[0]));
        byte_ready = 1'b1;
        @(negedge clk);
        byte_ready = 1'b0;
        check("rst_mid_second_byte", 32'(byte_out), 32'(exp_q[1]));
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_valid_drop", 32'(byte_valid), 32'(1'b0));
        check("rst_mid_ready", 32'(cmd_ready), 32'(1'b1));
        @(negedge clk);
        reset = 1'b0;
        model_cache = -1;
        run_req(OP_SET_LEDS,    8'd3, 12'h00A, 0, -1, 1'b0);

        // Randomized requests.
        for (int n = 0; n < 60; n++) begin
            cmd_op_e    op;
            logic [7:0] idx;
            logic [11:0] val;
            op  = cmd_op_e'($urandom_range(7));
            idx = 8'($urandom_range(9));
            val = ($urandom_range(1) == 1) ? 12'($urandom_range(160)) : 12'($urandom_range(4095));
            run_req(op, idx, val, int'($urandom_range(60)), -1, 1'($urandom_range(1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/xc_cmd_encoder.md
# xc_cmd_encoder

Command-stream generator for the correlator's UART control port. Accepts one high-level request at a time (clear, LEDs, baud, cross/auto delay, clock divider, voltage, capture enable), expands it into the exact command-byte sequence the correlator decoder expects, and hands the bytes one by one to a UART transmitter over a valid/ready handshake. Used by the companion controller FPGA and by the correlator bench as the host-side end of the control link.

## Interface
- NUM_INPUTS, 8: number of correlator lines; valid index range 0..NUM_INPUTS-1
- DELAY_SIZE, 150: delay-line depth; delay values saturate to DELAY_SIZE-1
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  request present
- cmd_ready  out  1  encoder idle, request accepted when cmd_valid & cmd_ready
- cmd_op  in  3  request code (package enum, below)
- cmd_index  in  8  target line for per-line ops
- cmd_value  in  12  payload; nibble ops use [3:0], capture uses [0]
- byte_out  out  8  command byte to UART TX
- byte_valid  out  1  byte_out valid
- byte_ready  in  1  UART TX consumes byte when byte_valid & byte_ready
- cmd_error  out  1  one-cycle pulse: request rejected or value saturated
- busy  out  1  ~cmd_ready

## Operation
- Request codes: OP_CLEAR, OP_SET_LEDS, OP_SET_BAUD, OP_SET_CROSS, OP_SET_AUTO, OP_SET_FREQ_DIV, OP_SET_VOLTAGE, OP_CAPTURE.
- Wire opcodes (low nibble): CLEAR 0x0, SET_INDEX 0x1, SET_LEDS 0x2, SET_BAUD_RATE 0x3, delay 0x4|slice, SET_FREQ_DIV 0x8, SET_VOLTAGE 0x9, ENABLE_CAPTURE 0xD.
- Per-line ops (CLEAR, LEDS, CROSS, AUTO, VOLTAGE): cmd_index >= NUM_INPUTS -> cmd_error pulse, no bytes, stay IDLE.
- Index prefix: emitted only if cmd_index != cached index or cache invalid; 4 bytes, k=0..3: {k[1:0], cmd_index[2k+1:2k], 4'h1}. Cache updated after the last prefix byte transfers.
- Nibble ops: single byte {cmd_value[3:0], opcode}. CAPTURE: {3'b0, cmd_value[0], 4'hD}. CLEAR: 0x00.
- Delay ops: v = min(cmd_value, DELAY_SIZE-1); cmd_error pulses when saturated, request still sent. Bytes k=0..3: {auto, v[3k+2:3k], 2'b01, k[1:0]}, then a fifth commit byte identical to k=3 (decoder latches the previous tmp value, so the repeat makes the full value take effect).
- FSM: IDLE -> PREFIX (0-4 bytes) -> BODY (1 or 5 bytes) -> IDLE. Byte counter 3 bits.

## Timing
- Reset values: cmd_ready 1, byte_valid 0, byte_out 0x00, cmd_error 0, busy 0, index cache invalid, FSM IDLE.
- Request accepted in cycle N -> byte_valid high with first byte from N+1 (registered outputs).
- byte_out held stable while byte_valid & ~byte_ready; next byte (or deassertion) the cycle after transfer; back-to-back bytes allowed with byte_ready held high.
- cmd_ready returns high the cycle after the final byte transfers; rejected requests: cmd_error at N+1, cmd_ready stays high.
- Reset mid-sequence: byte_valid drops immediately, partial sequence abandoned, cache invalidated (next per-line op resends prefix).
- cmd_valid while busy: ignored, no queueing.

## Structure
- Package xc_cmd_pkg: request enum, wire opcode constants, bytes-per-op constants; shared with the correlator decoder bench.
- Single module; no sub-module needed (FSM + counter + shift of value slices).

## Test plan
- After reset, OP_SET_LEDS idx 3 val 0xA -> bytes 0x31, 0x41, 0x81, 0xC1, 0xA2; cmd_ready high after last.
- Then OP_SET_VOLTAGE idx 3 val 5 -> single byte 0x59 (cache hit).
- OP_SET_AUTO idx 3 val 90 -> 0xA4, 0xB5, 0x96, 0x87, 0x87; OP_SET_CROSS idx 3 val 200 -> cmd_error pulse, bytes 0x54, 0x25, 0x26, 0x07, 0x07 (149).
- OP_CAPTURE val 1 -> 0x1D; OP_SET_CLEAR idx 8 -> cmd_error at N+1, zero bytes, cmd_ready never drops.
- byte_ready low for 10 cycles during delay sequence -> byte_out unchanged, no byte lost or duplicated; reset asserted mid-prefix -> byte_valid low same cycle, next OP_SET_LEDS idx 3 resends full prefix.
